// File: rtl/bank_burst_if.sv
// Command, write-beat, read-beat, status and display signals of bank_burst.
// The requester drives through the master modport; the bank uses slave.
interface bank_burst_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_clear;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              finish;
  logic              busy;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;

  modport master (
    output req_valid, req_write, req_clear, req_addr, req_len,
    output wr_data, wr_valid, disp_addr,
    input  req_ready, wr_ready, rd_data, rd_valid, finish, busy, disp_data
  );

  modport slave (
    input  req_valid, req_write, req_clear, req_addr, req_len,
    input  wr_data, wr_valid, disp_addr,
    output req_ready, wr_ready, rd_data, rd_valid, finish, busy, disp_data
  );
endinterface

// File: rtl/bank_burst.sv
// Burst-capable memory bank: one command port (write burst, read burst,
// whole-bank clear) and one independent display read port that serves
// the scan-out path every cycle. All outputs are registered.
module bank_burst #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter int                LEN_W     = 4,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input logic          clock,
  input logic          reset,
  bank_burst_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  localparam logic [LEN_W:0]  CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W:0]    cnt_r;
  logic              req_ready_r;
  logic              wr_ready_r;
  logic              busy_r;
  logic              finish_r;
  logic              rd_valid_r;
  logic [DATA_W-1:0] rd_data_r;
  logic [DATA_W-1:0] disp_data_r;

  logic              accept_s;
  logic              we_s;
  logic              issue_s;
  logic              last_s;
  logic [ADDR_W-1:0] wa_s;
  logic [DATA_W-1:0] wd_s;

  // Next-state decode plus per-cycle memory write and read-issue strobes
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    we_s        = 1'b0;
    issue_s     = 1'b0;
    last_s      = 1'b0;
    wa_s        = addr_r;
    wd_s        = bus.wr_data;
    case (state_r)
      ST_IDLE: begin
        accept_s = bus.req_valid & req_ready_r;
        if (accept_s) begin
          if (bus.req_clear) begin
            state_nxt_s = ST_CLEAR;
          end else if (bus.req_write) begin
            state_nxt_s = ST_WRITE;
          end else begin
            state_nxt_s = ST_READ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (bus.wr_valid) begin
          we_s   = 1'b1;
          last_s = (cnt_r == CNT_ONE);
          if (last_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_WRITE;
          end
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_READ: begin
        issue_s = 1'b1;
        last_s  = (cnt_r == CNT_ONE);
        if (last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_CLEAR: begin
        we_s   = 1'b1;
        wd_s   = CLEAR_VAL;
        last_s = &addr_r;
        if (last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Memory array write port; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (we_s) begin
      mem_r[wa_s] <= wd_s;
    end
  end

  // FSM state, working address/count and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      cnt_r       <= {(LEN_W+1){1'b0}};
      req_ready_r <= 1'b0;
      wr_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      finish_r    <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_data_r   <= {DATA_W{1'b0}};
      disp_data_r <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      req_ready_r <= (state_nxt_s == ST_IDLE);
      wr_ready_r  <= (state_nxt_s == ST_WRITE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      finish_r    <= last_s;
      rd_valid_r  <= issue_s;
      rd_data_r   <= issue_s ? mem_r[addr_r] : {DATA_W{1'b0}};
      // Display read samples before any same-cycle write lands
      disp_data_r <= mem_r[bus.disp_addr];
      if (accept_s) begin
        addr_r <= bus.req_clear ? {ADDR_W{1'b0}} : bus.req_addr;
        cnt_r  <= {1'b0, bus.req_len} + CNT_ONE;
      end else if (we_s || issue_s) begin
        addr_r <= addr_r + ADDR_ONE;
        cnt_r  <= cnt_r - CNT_ONE;
      end else begin
        addr_r <= addr_r;
        cnt_r  <= cnt_r;
      end
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.wr_ready  = wr_ready_r;
  assign bus.busy      = busy_r;
  assign bus.finish    = finish_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.disp_data = disp_data_r;

endmodule

// File: tb/tb_bank_burst.sv
// Self-checking bench for bank_burst: table-driven write/read bursts with a
// read-data scoreboard, plus hand sequences for stall, collision, reset, clear.
module tb_bank_burst;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bank_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  bank_burst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CLEAR_VAL(8'h00)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] model [0:255];
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] addr;
    int         len;
    logic [7:0] base;
    logic [7:0] step;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    check("req_ready_wait", bus.req_ready, 1);
  endtask

  // Scoreboard: pop expected read data on every valid beat
  always @(negedge clock) begin
    if (reset) begin
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          check("rd_data", bus.rd_data, exp_q.pop_front());
        end
      end else begin
        check("rd_data_idle_zero", bus.rd_data, 0);
      end
    end
  end

  task automatic write_burst(input logic [7:0] addr, input int len, input logic [7:0] base,
                             input logic [7:0] step, input int stall_at, input int stall_len);
    logic [7:0] d;
    logic [7:0] a;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_clear = 1'b0;
    bus.req_addr  = addr;
    bus.req_len   = 4'(len);
    wait_ready();
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          bus.wr_valid = 1'b0;
          bus.wr_data  = 8'hEE;
          check("wr_ready_stall", bus.wr_ready, 1);
          check("wr_finish_stall", bus.finish, 0);
          tick();
        end
      end
      d = 8'(base + 8'(i) * step);
      a = 8'(addr + 8'(i));
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      check("wr_ready_beat", bus.wr_ready, 1);
      check("wr_finish_early", bus.finish, 0);
      model[a] = d;
      tick();
    end
    bus.wr_valid = 1'b0;
    check("wr_finish", bus.finish, 1);
    check("wr_idle_ready", bus.req_ready, 1);
    check("wr_ready_off", bus.wr_ready, 0);
    check("wr_busy_off", bus.busy, 0);
  endtask

  task automatic read_burst(input logic [7:0] addr, input int len);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_clear = 1'b0;
    bus.req_addr  = addr;
    bus.req_len   = 4'(len);
    wait_ready();
    for (int i = 0; i <= len; i++) begin
      exp_q.push_back(model[8'(addr + 8'(i))]);
    end
    tick();
    bus.req_valid = 1'b0;
    check("rd_first_latency", bus.rd_valid, 0);
    check("rd_busy", bus.busy, 1);
    for (int k = 0; k <= len; k++) begin
      tick();
      check("rd_valid", bus.rd_valid, 1);
      check("rd_finish", bus.finish, (k == len));
      check("rd_ready", bus.req_ready, (k == len));
    end
    tick();
    check("rd_valid_end", bus.rd_valid, 0);
    check("rd_q_empty", exp_q.size(), 0);
  endtask

  task automatic disp_check(input string name, input logic [7:0] addr, input logic [7:0] exp);
    bus.disp_addr = addr;
    tick();
    check(name, bus.disp_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{addr: 8'h10, len: 3,  base: 8'hA1, step: 8'h01, exp_last: 8'hA4};
    vecs[1] = '{addr: 8'h40, len: 0,  base: 8'h77, step: 8'h00, exp_last: 8'h77};
    vecs[2] = '{addr: 8'h80, len: 15, base: 8'h01, step: 8'h03, exp_last: 8'h2E};
    vecs[3] = '{addr: 8'hF8, len: 15, base: 8'hC0, step: 8'h01, exp_last: 8'hCF};
    vecs[4] = '{addr: 8'hFE, len: 3,  base: 8'h11, step: 8'h11, exp_last: 8'h44};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_clear = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_len   = 4'h0;
    bus.wr_data   = 8'h00;
    bus.wr_valid  = 1'b0;
    bus.disp_addr = 8'h00;

    // Reset state
    repeat (3) tick();
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_finish", bus.finish, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_disp_data", bus.disp_data, 0);
    reset = 1'b1;
    check("rel_ready_low", bus.req_ready, 0);
    tick();
    check("rel_ready_high", bus.req_ready, 1);

    // Table of write bursts, each read back immediately after finish
    for (int v = 0; v < 5; v++) begin
      write_burst(vecs[v].addr, vecs[v].len, vecs[v].base, vecs[v].step, -1, 0);
      read_burst(vecs[v].addr, vecs[v].len);
      disp_check("disp_last", 8'(vecs[v].addr + 8'(vecs[v].len)), vecs[v].exp_last);
    end
    disp_check("wrap_disp_00", 8'h00, 8'h33);
    disp_check("wrap_disp_01", 8'h01, 8'h44);

    // Write stall of two cycles before the third beat
    write_burst(8'h30, 3, 8'h61, 8'h01, 2, 2);
    read_burst(8'h30, 3);

    // Display read-before-write collision
    write_burst(8'h20, 0, 8'h11, 8'h00, -1, 0);
    bus.disp_addr = 8'h20;
    tick();
    write_burst(8'h20, 0, 8'h5A, 8'h00, -1, 0);
    check("coll_old", bus.disp_data, 8'h11);
    tick();
    check("coll_new", bus.disp_data, 8'h5A);

    // Reset during the second beat of a four-beat read
    write_burst(8'h10, 3, 8'hA1, 8'h01, -1, 0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h10;
    bus.req_len   = 4'd3;
    wait_ready();
    for (int i = 0; i < 4; i++) exp_q.push_back(model[8'(8'h10 + 8'(i))]);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    check("mid_rd_valid", bus.rd_valid, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_rd_valid", bus.rd_valid, 0);
    check("mid_rst_finish", bus.finish, 0);
    check("mid_rst_busy", bus.busy, 0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    check("mid_rel_ready_low", bus.req_ready, 0);
    tick();
    check("mid_rel_ready_high", bus.req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      check("mid_no_finish", bus.finish, 0);
      tick();
    end
    read_burst(8'h10, 3);

    // Whole-bank clear with req_write also high
    bus.req_valid = 1'b1;
    bus.req_clear = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h55;
    wait_ready();
    tick();
    bus.req_valid = 1'b0;
    bus.req_clear = 1'b0;
    check("clr_wr_ready", bus.wr_ready, 0);
    n = 0;
    while (bus.busy && n < 400) begin
      n++;
      tick();
    end
    check("clr_busy_cycles", n, 256);
    check("clr_finish", bus.finish, 1);
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    disp_check("clr_disp_00", 8'h00, 8'h00);
    disp_check("clr_disp_7f", 8'h7F, 8'h00);
    disp_check("clr_disp_ff", 8'hFF, 8'h00);
    read_burst(8'hFE, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
